// File: rtl/wakeup_tag_bcast_pkg.sv
// Shared constants and slot payload for the issue-stage wakeup tag bus.
package wakeup_tag_bcast_pkg;

    localparam int unsigned ISSUE_NUM = 4;
    localparam int unsigned PRF_WIDTH = 6;
    localparam int unsigned MAX_LAT   = 8;
    localparam int unsigned LAT_W     = 4;

    typedef struct packed {
        logic                 v;
        logic [PRF_WIDTH-1:0] prd;
    } wk_slot_t;

    // Map out-of-range latencies onto 1..MAX_LAT.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        logic [LAT_W-1:0] res;
        res = lat;
        if (lat == '0) begin
            res = LAT_W'(1);
        end else if (lat > LAT_W'(MAX_LAT)) begin
            res = LAT_W'(MAX_LAT);
        end
        return res;
    endfunction

endpackage

// File: rtl/wakeup_delay_line.sv
// One issue port: delays each granted dest tag by its FU latency and tracks
// occupancy of a non-pipelined FU.
module wakeup_delay_line
    import wakeup_tag_bcast_pkg::*;
#(
    parameter bit NONPIPE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 grant_i,
    input  logic [PRF_WIDTH-1:0] prd_i,
    input  logic                 prd_v_i,
    input  logic [LAT_W-1:0]     lat_i,
    output logic                 wk_v_o,
    output logic [PRF_WIDTH-1:0] wk_prd_o,
    output logic                 port_rdy_o,
    output logic                 err_c_o
);

    localparam int LAST = int'(MAX_LAT) - 1;

    wk_slot_t [MAX_LAT-1:0] slot_q, slot_d;
    logic [LAT_W-1:0]       busy_q, busy_d;
    logic                   rdy_q, rdy_d;
    logic [LAT_W-1:0]       lat_c;
    logic                   take_c;
    logic                   write_c;
    logic                   placed_c;
    int                     tgt_c;

    // Shift, insert with late-slot fallback, and busy-counter update.
    always_comb begin
        slot_d   = '0;
        busy_d   = busy_q;
        placed_c = 1'b0;
        lat_c    = clamp_lat(lat_i);
        tgt_c    = int'(lat_c) - 1;
        take_c   = grant_i & rdy_q & ~flush_i;
        write_c  = take_c & prd_v_i & (prd_i != '0);

        for (int i = 0; i < LAST; i++) begin
            slot_d[i] = slot_q[i+1];
        end

        // The top slot is only a direct target; collisions never spill into it.
        for (int k = 0; k <= LAST; k++) begin
            if (write_c && !placed_c && !slot_d[k].v &&
                ((k == tgt_c) || ((k > tgt_c) && (k < LAST)))) begin
                slot_d[k].v   = 1'b1;
                slot_d[k].prd = prd_i;
                placed_c      = 1'b1;
            end
        end

        if (busy_q != '0) begin
            busy_d = busy_q - LAT_W'(1);
        end
        if (NONPIPE && take_c) begin
            busy_d = lat_c;
        end

        if (flush_i) begin
            slot_d = '0;
            busy_d = '0;
        end

        rdy_d = NONPIPE ? (busy_d == '0) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            busy_q <= '0;
            rdy_q  <= 1'b1;
        end else begin
            slot_q <= slot_d;
            busy_q <= busy_d;
            rdy_q  <= rdy_d;
        end
    end

    assign wk_v_o     = slot_q[0].v;
    assign wk_prd_o   = slot_q[0].prd;
    assign port_rdy_o = rdy_q;
    assign err_c_o    = (grant_i & ~rdy_q & ~flush_i) | (write_c & ~placed_c);

endmodule

// File: rtl/wakeup_tag_bcast.sv
// Wakeup tag bus driver: one delay line per issue port plus a sticky drop flag.
module wakeup_tag_bcast
    import wakeup_tag_bcast_pkg::*;
#(
    parameter logic [ISSUE_NUM-1:0] NONPIPE = 4'b1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic [ISSUE_NUM-1:0]           arbit_grant_i,
    input  logic [ISSUE_NUM*PRF_WIDTH-1:0] arbit_prd_i,
    input  logic [ISSUE_NUM-1:0]           arbit_prd_v_i,
    input  logic [ISSUE_NUM*LAT_W-1:0]     arbit_lat_i,
    output logic [ISSUE_NUM*PRF_WIDTH-1:0] wk_prd_o,
    output logic [ISSUE_NUM-1:0]           wk_v_o,
    output logic [ISSUE_NUM-1:0]           port_rdy_o,
    output logic                           bcast_err_o
);

    logic [ISSUE_NUM-1:0] err_c;
    logic                 bcast_err_q, bcast_err_d;

    for (genvar p = 0; p < int'(ISSUE_NUM); p++) begin : g_port
        wakeup_delay_line #(
            .NONPIPE (NONPIPE[p])
        ) u_line (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (flush_i),
            .grant_i    (arbit_grant_i[p]),
            .prd_i      (arbit_prd_i[p*PRF_WIDTH +: PRF_WIDTH]),
            .prd_v_i    (arbit_prd_v_i[p]),
            .lat_i      (arbit_lat_i[p*LAT_W +: LAT_W]),
            .wk_v_o     (wk_v_o[p]),
            .wk_prd_o   (wk_prd_o[p*PRF_WIDTH +: PRF_WIDTH]),
            .port_rdy_o (port_rdy_o[p]),
            .err_c_o    (err_c[p])
        );
    end

    always_comb begin
        bcast_err_d = bcast_err_q | (|err_c);
    end

    // Sticky until reset; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_err_q <= 1'b0;
        end else begin
            bcast_err_q <= bcast_err_d;
        end
    end

    assign bcast_err_o = bcast_err_q;

endmodule
